// File: rtl/servile_pkg.sv
// Shared definitions for the servile memory-bus arbiter: master indices and FSM encoding.
package servile_pkg;

  localparam int M_IBUS = 0;
  localparam int M_DBUS = 1;
  localparam int M_LOAD = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

endpackage

// File: rtl/servile_rr_pick.sv
// Combinational round-robin picker: first requester scanning upward from last+1, wrapping.
module servile_rr_pick #(
  parameter int N  = 3,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [MW-1:0] index
);

  // Scan from the farthest offset down so the nearest requester after last is written last.
  always_comb begin
    pick  = '0;
    index = '0;
    for (int i = N; i >= 1; i--) begin
      for (int k = 0; k < N; k++) begin
        if ((k == (int'(last) + i) % N) && req[k]) begin
          pick    = '0;
          pick[k] = 1'b1;
          index   = MW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/servile_wb_rr_arbiter.sv
// Registered round-robin Wishbone arbiter sharing the servile memory bus between masters,
// holding each grant until ack, abort or watchdog termination.
module servile_wb_rr_arbiter
  import servile_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 255,
  parameter int MW          = $clog2(NUM_MASTERS),
  parameter int TW          = $clog2(TIMEOUT + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [32*NUM_MASTERS-1:0] i_m_adr,
  input  logic [32*NUM_MASTERS-1:0] i_m_dat,
  input  logic [4*NUM_MASTERS-1:0]  i_m_sel,
  input  logic [NUM_MASTERS-1:0]    i_m_we,
  input  logic [NUM_MASTERS-1:0]    i_m_stb,
  output logic [31:0]               o_m_rdt,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [3:0]                o_wb_sel,
  output logic                      o_wb_we,
  output logic                      o_wb_stb,
  input  logic [31:0]               i_wb_rdt,
  input  logic                      i_wb_ack,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic                      o_busy
);

  // TIMEOUT=0 yields TW=0; keep a one-bit counter so the logic stays well-formed.
  localparam int TWI = (TW < 1) ? 1 : TW;
  localparam logic [TWI-1:0] WD_LAST = TWI'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TWI-1:0] WD_MAX  = '1;

  state_t                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [MW-1:0]            gidx_q, gidx_d;
  logic [MW-1:0]            last_q, last_d;
  logic [TWI-1:0]           wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0]   pick;
  logic [MW-1:0]            pick_idx;

  logic [31:0]              g_adr, g_dat;
  logic [3:0]               g_sel;
  logic                     g_we, g_stb;
  logic                     wd_hit;

  servile_rr_pick #(
    .N  (NUM_MASTERS),
    .MW (MW)
  ) u_pick (
    .req   (i_m_stb),
    .last  (last_q),
    .pick  (pick),
    .index (pick_idx)
  );

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_stb = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gidx_q == MW'(k)) begin
        g_adr = i_m_adr[32*k +: 32];
        g_dat = i_m_dat[32*k +: 32];
        g_sel = i_m_sel[4*k +: 4];
        g_we  = i_m_we[k];
        g_stb = i_m_stb[k];
      end
    end
  end

  assign wd_hit  = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  assign o_grant = grant_q;
  assign o_busy  = (state_q == S_BUS);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= MW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    wdog_d   = wdog_q;
    o_m_rdt  = '0;
    o_m_ack  = '0;
    o_m_err  = '0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    o_wb_stb = 1'b0;

    case (state_q)
      S_IDLE: begin
        wdog_d  = '0;
        grant_d = '0;
        if (|i_m_stb) begin
          state_d = S_BUS;
          grant_d = pick;
          gidx_d  = pick_idx;
        end
      end
      S_BUS: begin
        o_wb_adr = g_adr;
        o_wb_dat = g_dat;
        o_wb_sel = g_sel;
        o_wb_we  = g_we;
        o_wb_stb = g_stb;
        wdog_d   = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
        // Exit priority: ack, then master abort, then watchdog.
        if (i_wb_ack || !g_stb || wd_hit) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          wdog_d  = '0;
          if (i_wb_ack) begin
            o_m_ack = grant_q;
            o_m_rdt = i_wb_rdt;
          end else if (g_stb) begin
            o_m_err  = grant_q;
            o_wb_stb = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_servile_wb_rr_arbiter.sv
// Directed bench for servile_wb_rr_arbiter: expected grants and acks/errs are queued when
// stimulus is set up and popped as the arbiter produces them.
module tb_servile_wb_rr_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] m_adr, m_dat;
  logic [4*N-1:0]  m_sel;
  logic [N-1:0]    m_we, m_stb;
  logic [31:0]     m_rdt;
  logic [N-1:0]    m_ack, m_err;
  logic [31:0]     wb_adr, wb_dat, wb_rdt;
  logic [3:0]      wb_sel;
  logic            wb_we, wb_stb, wb_ack;
  logic [N-1:0]    grant;
  logic            busy;

  always #5 clk = ~clk;

  servile_wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_stb(m_stb),
    .o_m_rdt(m_rdt), .o_m_ack(m_ack), .o_m_err(m_err),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
    .o_wb_stb(wb_stb), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_grant(grant), .o_busy(busy)
  );

  typedef struct { int idx; int cyc; } gexp_t;
  typedef struct { logic [2:0] ack; logic [2:0] err; logic [31:0] rdt; int cyc; } eexp_t;

  gexp_t        gq[$];
  eexp_t        eq[$];
  int           n_assert = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           ack_at = 0;
  int           bus_cnt = 0;
  int           pend[N];
  logic         prev_stb = 1'b0;
  logic [N-1:0] done_seen = '0;

  function automatic logic [31:0] adr_of(input int k);
    return 32'hA000_0000 + 32'(k) * 32'h10;
  endfunction

  function automatic logic [31:0] dat_of(input int k);
    return 32'h5A00_0000 + 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    gexp_t g;
    eexp_t e;
    done_seen = m_ack | m_err;
    if (wb_stb && !prev_stb) begin
      if (gq.size() == 0) chk("grant_unexpected", 32'(grant), 32'h0);
      else begin
        g = gq.pop_front();
        chk("grant", 32'(grant), 32'(1) << g.idx);
        chk("wb_adr", wb_adr, adr_of(g.idx));
        chk("wb_dat", wb_dat, dat_of(g.idx));
        chk("wb_we", 32'(wb_we), 32'(g.idx == 1));
        chk("wb_sel", 32'(wb_sel), 32'hF);
        if (g.cyc >= 0) chk("grant_cycle", 32'(cyc), 32'(g.cyc));
      end
    end
    if (m_ack != 0 || m_err != 0) begin
      if (eq.size() == 0) chk("event_unexpected", 32'({m_ack, m_err}), 32'h0);
      else begin
        e = eq.pop_front();
        chk("ack", 32'(m_ack), 32'(e.ack));
        chk("err", 32'(m_err), 32'(e.err));
        chk("rdt", m_rdt, e.rdt);
        if (e.cyc >= 0) chk("event_cycle", 32'(cyc), 32'(e.cyc));
        if (m_err != 0) chk("err_stb_low", 32'(wb_stb), 32'h0);
      end
    end else begin
      chk("rdt_idle", m_rdt, 32'h0);
    end
    prev_stb = wb_stb;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < N; k++) begin
      if (done_seen[k] && pend[k] > 0) pend[k]--;
      m_stb[k] = (pend[k] > 0);
    end
    bus_cnt = busy ? bus_cnt + 1 : 0;
    wb_ack  = (ack_at > 0) && busy && (bus_cnt == ack_at);
    done_seen = '0;
  endtask

  task automatic set_req(input int a, input int b, input int c);
    pend[0] = a;
    pend[1] = b;
    pend[2] = c;
    for (int k = 0; k < N; k++) m_stb[k] = (pend[k] > 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stb"}, 32'(wb_stb), 32'h0);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_ack"}, 32'(m_ack), 32'h0);
    chk({tag, "_err"}, 32'(m_err), 32'h0);
    chk({tag, "_adr"}, wb_adr, 32'h0);
    chk({tag, "_rdt"}, m_rdt, 32'h0);
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    set_req(0, 0, 0);
    wb_ack = 1'b0;
    ack_at = 0;
    tick();
    chk_zero_outputs("rst");
  endtask

  task automatic release_reset();
    rst = 1'b0;
    cyc = 0;
    bus_cnt = 0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (gq.size() != 0 || eq.size() != 0); i++) tick();
    chk("drain_left", 32'(gq.size() + eq.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wb_ack = 1'b0;
    wb_rdt = 32'h0;
    m_stb = '0;
    m_sel = '1;
    m_we = 3'b010;
    for (int k = 0; k < N; k++) begin
      m_adr[32*k +: 32] = adr_of(k);
      m_dat[32*k +: 32] = dat_of(k);
    end

    // Masters 0 and 1 after reset; slave acks on the third bus cycle.
    hold_reset();
    wb_rdt = 32'h1234_5678;
    set_req(1, 1, 0);
    ack_at = 3;
    gq.push_back('{idx: 0, cyc: 1});
    eq.push_back('{ack: 3'b001, err: 3'b000, rdt: 32'h1234_5678, cyc: 3});
    gq.push_back('{idx: 1, cyc: 5});
    eq.push_back('{ack: 3'b010, err: 3'b000, rdt: 32'h1234_5678, cyc: 7});
    release_reset();
    drain(40);

    // All masters requesting twice: rotation 0,1,2,0,1,2.
    hold_reset();
    set_req(2, 2, 2);
    ack_at = 2;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        gq.push_back('{idx: k, cyc: 1 + 3 * (3 * r + k)});
        eq.push_back('{ack: 3'(1 << k), err: 3'b000, rdt: 32'h1234_5678, cyc: 2 + 3 * (3 * r + k)});
      end
    end
    release_reset();
    drain(60);

    // Read by master 2; read data visible only with its ack.
    hold_reset();
    wb_rdt = 32'hDEAD_BEEF;
    set_req(0, 0, 1);
    ack_at = 2;
    gq.push_back('{idx: 2, cyc: 1});
    eq.push_back('{ack: 3'b100, err: 3'b000, rdt: 32'hDEAD_BEEF, cyc: 2});
    release_reset();
    drain(20);

    // Slave never acks: watchdog terminates master 1, then master 2.
    hold_reset();
    set_req(0, 1, 1);
    ack_at = 0;
    gq.push_back('{idx: 1, cyc: 1});
    eq.push_back('{ack: 3'b000, err: 3'b010, rdt: 32'h0, cyc: 8});
    gq.push_back('{idx: 2, cyc: 10});
    eq.push_back('{ack: 3'b000, err: 3'b100, rdt: 32'h0, cyc: 17});
    release_reset();
    drain(40);
    tick();
    chk("wd_idle_busy", 32'(busy), 32'h0);

    // Ack on the final watchdog cycle wins over the timeout.
    hold_reset();
    wb_rdt = 32'hCAFE_0005;
    set_req(1, 0, 0);
    ack_at = TO;
    gq.push_back('{idx: 0, cyc: 1});
    eq.push_back('{ack: 3'b001, err: 3'b000, rdt: 32'hCAFE_0005, cyc: 8});
    release_reset();
    drain(30);

    // Master 1 aborts mid-transfer, then reset lands in master 0's transfer.
    hold_reset();
    set_req(0, 1, 0);
    ack_at = 0;
    gq.push_back('{idx: 1, cyc: 1});
    release_reset();
    tick();
    tick();
    tick();
    pend[1] = 0;
    m_stb[1] = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_grant", 32'(grant), 32'h0);
    set_req(1, 0, 0);
    gq.push_back('{idx: 0, cyc: -1});
    tick();
    tick();
    tick();
    chk("mid_grant_seen", 32'(gq.size()), 32'h0);
    chk("mid_busy", 32'(busy), 32'h1);
    set_req(1, 1, 1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("async_rst");
    tick();
    ack_at = 2;
    for (int k = 0; k < N; k++) begin
      gq.push_back('{idx: k, cyc: 1 + 3 * k});
      eq.push_back('{ack: 3'(1 << k), err: 3'b000, rdt: 32'hCAFE_0005, cyc: 2 + 3 * k});
    end
    release_reset();
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
